// File: rtl/pipe_ctrl_pkg.sv
// Shared encodings for the pipeline sequencer: FSM states and forwarding-source codes.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_HALT     = 2'd2
  } state_e;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

endpackage

// File: rtl/pipe_fwd_unit.sv
// EX-stage operand forwarding comparator: picks EX/MEM, MEM/WB or regfile per source.
module pipe_fwd_unit
  import pipe_ctrl_pkg::*;
(
  input  logic [4:0] ex_rs,
  input  logic [4:0] ex_rt,
  input  logic [4:0] mem_rw,
  input  logic       mem_regwrite,
  input  logic [4:0] wb_rw,
  input  logic       wb_regwrite,
  output logic [1:0] fwd_a_sel,
  output logic [1:0] fwd_b_sel
);

  // The younger MEM result shadows WB; $0 is hardwired and never forwarded.
  function automatic logic [1:0] fwd_sel(input logic [4:0] src,
                                         input logic [4:0] m_rw, input logic m_we,
                                         input logic [4:0] w_rw, input logic w_we);
    if (m_we && (m_rw != 5'd0) && (m_rw == src))
      return FWD_MEM;
    else if (w_we && (w_rw != 5'd0) && (w_rw == src))
      return FWD_WB;
    else
      return FWD_RF;
  endfunction

  assign fwd_a_sel = fwd_sel(ex_rs, mem_rw, mem_regwrite, wb_rw, wb_regwrite);
  assign fwd_b_sel = fwd_sel(ex_rt, mem_rw, mem_regwrite, wb_rw, wb_regwrite);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Five-stage pipeline sequencer: hazard priority, RAM-wait/halt FSM, forwarding select
// and performance counters.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int CNT_W       = 32,
  parameter int MEM_TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_use_rs,
  input  logic             id_use_rt,
  input  logic [4:0]       ex_rs,
  input  logic [4:0]       ex_rt,
  input  logic [4:0]       ex_rw,
  input  logic             ex_regwrite,
  input  logic             ex_memtoreg,
  input  logic             ex_branch_taken,
  input  logic [4:0]       mem_rw,
  input  logic             mem_regwrite,
  input  logic             mem_req,
  input  logic             mem_ready,
  input  logic [4:0]       wb_rw,
  input  logic             wb_regwrite,
  input  logic             wb_halt,
  input  logic             resume,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             exmem_en,
  output logic             memwb_en,
  output logic [1:0]       fwd_a_sel,
  output logic [1:0]       fwd_b_sel,
  output logic             halted,
  output logic             mem_err,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int WAIT_W = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

  state_e            state;
  logic [WAIT_W-1:0] wait_cnt;
  logic              mem_stall, load_use;
  logic              halt_c, stall_c, redir_c, lu_c;
  logic [1:0]        fwd_a_raw, fwd_b_raw;

  assign mem_stall = mem_req & ~mem_ready;
  assign load_use  = ex_memtoreg & ex_regwrite & (ex_rw != 5'd0) &
                     ((id_use_rs & (id_rs == ex_rw)) | (id_use_rt & (id_rt == ex_rw)));

  always_comb begin
    pc_en      = 1'b0;
    ifid_en    = 1'b0;
    ifid_flush = 1'b0;
    idex_flush = 1'b0;
    exmem_en   = 1'b0;
    memwb_en   = 1'b0;
    halt_c     = 1'b0;
    stall_c    = 1'b0;
    redir_c    = 1'b0;
    lu_c       = 1'b0;
    if (rst) begin
      if ((state == ST_HALT) || ((state == ST_RUN) && wb_halt)) begin
        halt_c = 1'b1;
        // Resume lets the halting syscall retire in the same cycle it leaves HALT.
        if ((state == ST_HALT) && resume) begin
          pc_en    = 1'b1;
          ifid_en  = 1'b1;
          exmem_en = 1'b1;
          memwb_en = 1'b1;
        end
      end else if (mem_stall) begin
        stall_c = 1'b1;
      end else if (ex_branch_taken) begin
        redir_c    = 1'b1;
        pc_en      = 1'b1;
        ifid_en    = 1'b1;
        exmem_en   = 1'b1;
        memwb_en   = 1'b1;
        ifid_flush = 1'b1;
        idex_flush = 1'b1;
      end else if (load_use) begin
        lu_c       = 1'b1;
        idex_flush = 1'b1;
        exmem_en   = 1'b1;
        memwb_en   = 1'b1;
      end else begin
        pc_en    = 1'b1;
        ifid_en  = 1'b1;
        exmem_en = 1'b1;
        memwb_en = 1'b1;
      end
    end
  end

  pipe_fwd_unit u_fwd (
    .ex_rs       (ex_rs),
    .ex_rt       (ex_rt),
    .mem_rw      (mem_rw),
    .mem_regwrite(mem_regwrite),
    .wb_rw       (wb_rw),
    .wb_regwrite (wb_regwrite),
    .fwd_a_sel   (fwd_a_raw),
    .fwd_b_sel   (fwd_b_raw)
  );

  assign fwd_a_sel = rst ? fwd_a_raw : FWD_RF;
  assign fwd_b_sel = rst ? fwd_b_raw : FWD_RF;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= ST_RUN;
      wait_cnt <= '0;
      halted   <= 1'b0;
      mem_err  <= 1'b0;
    end else begin
      case (state)
        ST_RUN: begin
          if (wb_halt) begin
            state  <= ST_HALT;
            halted <= 1'b1;
          end else if (mem_stall) begin
            state <= ST_MEM_WAIT;
          end
        end
        ST_MEM_WAIT: begin
          if (mem_ready) begin
            state    <= ST_RUN;
            wait_cnt <= '0;
          end else if (wait_cnt == WAIT_LAST) begin
            state    <= ST_HALT;
            halted   <= 1'b1;
            mem_err  <= 1'b1;
            wait_cnt <= '0;
          end else begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
          end
        end
        ST_HALT: begin
          if (resume) begin
            state    <= ST_RUN;
            halted   <= 1'b0;
            mem_err  <= 1'b0;
            wait_cnt <= '0;
          end
        end
        default: begin
          state  <= ST_RUN;
          halted <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cycle_cnt <= '0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (state != ST_HALT)  cycle_cnt <= cycle_cnt + CNT_W'(1);
      if (stall_c || lu_c)   stall_cnt <= stall_cnt + CNT_W'(1);
      if (redir_c)           flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed-vector bench for pipe_hazard_ctrl with hand-computed expectations.
module tb_pipe_hazard_ctrl;

  localparam int CNT_W = 32;

  localparam logic [5:0] C_NORM  = 6'b110011;  // {pc,ifid_en,ifid_fl,idex_fl,exmem,memwb}
  localparam logic [5:0] C_FROZE = 6'b000000;
  localparam logic [5:0] C_REDIR = 6'b111111;
  localparam logic [5:0] C_LU    = 6'b000111;

  logic             clk = 1'b0;
  logic             rst;
  logic [4:0]       id_rs, id_rt, ex_rs, ex_rt, ex_rw, mem_rw, wb_rw;
  logic             id_use_rs, id_use_rt, ex_regwrite, ex_memtoreg, ex_branch_taken;
  logic             mem_regwrite, mem_req, mem_ready, wb_regwrite, wb_halt, resume;
  logic             pc_en, ifid_en, ifid_flush, idex_flush, exmem_en, memwb_en;
  logic [1:0]       fwd_a_sel, fwd_b_sel;
  logic             halted, mem_err;
  logic [CNT_W-1:0] cycle_cnt, stall_cnt, flush_cnt;
  logic [5:0]       ctrl;

  int n_vec = 0;
  int n_err = 0;

  assign ctrl = {pc_en, ifid_en, ifid_flush, idex_flush, exmem_en, memwb_en};

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.CNT_W(CNT_W), .MEM_TIMEOUT(16)) dut (
    .clk(clk), .rst(rst),
    .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
    .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rw(ex_rw), .ex_regwrite(ex_regwrite),
    .ex_memtoreg(ex_memtoreg), .ex_branch_taken(ex_branch_taken),
    .mem_rw(mem_rw), .mem_regwrite(mem_regwrite), .mem_req(mem_req), .mem_ready(mem_ready),
    .wb_rw(wb_rw), .wb_regwrite(wb_regwrite), .wb_halt(wb_halt), .resume(resume),
    .pc_en(pc_en), .ifid_en(ifid_en), .ifid_flush(ifid_flush), .idex_flush(idex_flush),
    .exmem_en(exmem_en), .memwb_en(memwb_en), .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel),
    .halted(halted), .mem_err(mem_err),
    .cycle_cnt(cycle_cnt), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  task automatic check_vec(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_inputs();
    id_rs = 0; id_rt = 0; id_use_rs = 0; id_use_rt = 0;
    ex_rs = 0; ex_rt = 0; ex_rw = 0; ex_regwrite = 0; ex_memtoreg = 0; ex_branch_taken = 0;
    mem_rw = 0; mem_regwrite = 0; mem_req = 0; mem_ready = 0;
    wb_rw = 0; wb_regwrite = 0; wb_halt = 0; resume = 0;
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    clear_inputs();
    rst = 1'b0;
    #3;
    check_vec("rst_ctrl", 32'(ctrl), 32'(C_FROZE));
    check_vec("rst_cycle", cycle_cnt, 0);
    check_vec("rst_halted", 32'({halted, mem_err}), 0);
    #5 rst = 1'b1;
    #1;
    check_vec("idle_ctrl", 32'(ctrl), 32'(C_NORM));
    tick(1);
    check_vec("idle_cycle", cycle_cnt, 1);

    // Load-use on rs
    ex_memtoreg = 1; ex_regwrite = 1; ex_rw = 5'd3; id_rs = 5'd3; id_use_rs = 1;
    #1 check_vec("lu_ctrl", 32'(ctrl), 32'(C_LU));
    tick(1);
    check_vec("lu_stall_cnt", stall_cnt, 1);

    // Load into $0 never stalls
    ex_rw = 5'd0; id_rs = 5'd0;
    #1 check_vec("lu0_ctrl", 32'(ctrl), 32'(C_NORM));
    tick(1);
    check_vec("lu0_stall_cnt", stall_cnt, 1);

    // Redirect beats load-use
    ex_rw = 5'd3; id_rs = 5'd3; ex_branch_taken = 1;
    #1 check_vec("redir_ctrl", 32'(ctrl), 32'(C_REDIR));
    tick(1);
    check_vec("redir_flush_cnt", flush_cnt, 1);
    check_vec("redir_stall_cnt", stall_cnt, 1);
    check_vec("redir_cycle", cycle_cnt, 4);

    // Three-cycle RAM wait
    clear_inputs();
    mem_req = 1;
    for (int i = 0; i < 3; i++) begin
      #1 check_vec("mwait_ctrl", 32'(ctrl), 32'(C_FROZE));
      tick(1);
    end
    check_vec("mwait_stall_cnt", stall_cnt, 4);
    mem_ready = 1;
    #1 check_vec("mready_ctrl", 32'(ctrl), 32'(C_NORM));
    tick(1);
    check_vec("mready_halted", 32'(halted), 0);
    check_vec("mready_cycle", cycle_cnt, 8);

    // RAM timeout: one RUN stall cycle then 16 MEM_WAIT cycles
    mem_ready = 0;
    tick(17);
    check_vec("tmo_halted", 32'(halted), 1);
    check_vec("tmo_mem_err", 32'(mem_err), 1);
    check_vec("tmo_cycle", cycle_cnt, 25);
    check_vec("tmo_stall_cnt", stall_cnt, 21);
    mem_req = 0;
    #1 check_vec("tmo_halt_ctrl", 32'(ctrl), 32'(C_FROZE));
    tick(1);
    check_vec("tmo_cycle_frozen", cycle_cnt, 25);
    resume = 1;
    #1 check_vec("tmo_resume_ctrl", 32'(ctrl), 32'(C_NORM));
    tick(1);
    resume = 0;
    check_vec("tmo_resume_err", 32'({halted, mem_err}), 0);
    check_vec("tmo_resume_cycle", cycle_cnt, 25);

    // Syscall halt in WB
    wb_halt = 1;
    #1 check_vec("sys_ctrl", 32'(ctrl), 32'(C_FROZE));
    tick(1);
    check_vec("sys_halted", 32'(halted), 1);
    check_vec("sys_cycle", cycle_cnt, 26);
    tick(1);
    check_vec("sys_cycle_frozen", cycle_cnt, 26);
    resume = 1;
    #1 check_vec("sys_resume_ctrl", 32'(ctrl), 32'(C_NORM));
    tick(1);
    resume = 0; wb_halt = 0;
    check_vec("sys_run_halted", 32'(halted), 0);
    #1 check_vec("sys_run_ctrl", 32'(ctrl), 32'(C_NORM));
    tick(1);
    check_vec("sys_run_cycle", cycle_cnt, 27);

    // Forwarding
    ex_rs = 5'd5; ex_rt = 5'd7; mem_rw = 5'd5; wb_rw = 5'd5; mem_regwrite = 1; wb_regwrite = 1;
    #1 check_vec("fwd_a_mem", 32'(fwd_a_sel), 32'(2'b10));
    check_vec("fwd_b_none", 32'(fwd_b_sel), 32'(2'b00));
    mem_regwrite = 0; ex_rt = 5'd5;
    #1 check_vec("fwd_a_wb", 32'(fwd_a_sel), 32'(2'b01));
    check_vec("fwd_b_wb", 32'(fwd_b_sel), 32'(2'b01));
    ex_rs = 5'd0; mem_rw = 5'd0; wb_rw = 5'd0; mem_regwrite = 1;
    #1 check_vec("fwd_a_r0", 32'(fwd_a_sel), 32'(2'b00));

    // Asynchronous reset in the middle of a RAM wait
    ex_rs = 5'd5; wb_rw = 5'd5; mem_rw = 5'd9;
    mem_req = 1; mem_ready = 0;
    tick(2);
    check_vec("pre_rst_stall", stall_cnt, 23);
    #2 rst = 1'b0;
    #1;
    check_vec("arst_ctrl", 32'(ctrl), 32'(C_FROZE));
    check_vec("arst_fwd", 32'({fwd_a_sel, fwd_b_sel}), 0);
    check_vec("arst_cnts", cycle_cnt | stall_cnt | flush_cnt, 0);
    tick(1);
    rst = 1'b1;
    clear_inputs();
    #1 check_vec("post_rst_ctrl", 32'(ctrl), 32'(C_NORM));
    tick(1);
    check_vec("post_rst_cycle", cycle_cnt, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
